// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between four clients and the round-robin arbiter.
// The master modport belongs to the requesting side and the slave modport to the arbiter.
interface rr_arbiter_4_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_sel;
    logic       gnt_valid;

    modport master (output req, input gnt, input gnt_sel, input gnt_valid);
    modport slave  (input req, output gnt, output gnt_sel, output gnt_valid);
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with registered index/one-hot grant and a hold limit
// that forces rotation when others are waiting.
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter_4_if.slave bus
);
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_ptr, w_ptr_nxt;
    logic [7:0] r_hold_cnt, w_hold_cnt_nxt;
    logic [1:0] r_gnt_sel, w_gnt_sel_nxt;
    logic       r_gnt_valid, w_gnt_valid_nxt;
    logic [3:0] r_gnt, w_gnt_nxt;

    logic [3:0] w_mask;
    logic [1:0] w_winner;
    logic       w_found;
    logic       w_take;

    // The holder is masked out so that "found" means another requester is pending.
    always_comb begin
        w_mask = bus.req;
        if (r_state == S_GRANT) w_mask[r_gnt_sel] = 1'b0;
        w_found  = |w_mask;
        w_winner = r_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (w_mask[r_ptr + 2'(i)]) w_winner = r_ptr + 2'(i);
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_gnt_sel_nxt   = r_gnt_sel;
        w_gnt_valid_nxt = r_gnt_valid;
        w_gnt_nxt       = r_gnt;
        w_take          = 1'b0;

        if (r_state == S_IDLE) begin
            w_take = w_found;
        end else if (!bus.req[r_gnt_sel]) begin
            if (w_found) begin
                w_take = 1'b1;
            end else begin
                w_state_nxt     = S_IDLE;
                w_gnt_valid_nxt = 1'b0;
                w_gnt_nxt       = 4'b0000;
            end
        end else if (r_hold_cnt == HOLD_LIM) begin
            w_take = w_found;
        end else begin
            w_hold_cnt_nxt = r_hold_cnt + 8'd1;
        end

        if (w_take) begin
            w_state_nxt     = S_GRANT;
            w_gnt_sel_nxt   = w_winner;
            w_gnt_valid_nxt = 1'b1;
            w_gnt_nxt       = 4'b0001 << w_winner;
            w_ptr_nxt       = w_winner + 2'd1;
            w_hold_cnt_nxt  = 8'd0;
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= 2'd0;
            r_hold_cnt  <= 8'd0;
            r_gnt_sel   <= 2'd0;
            r_gnt_valid <= 1'b0;
            r_gnt       <= 4'b0000;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_gnt_sel   <= w_gnt_sel_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_gnt       <= w_gnt_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_sel   = r_gnt_sel;
    assign bus.gnt_valid = r_gnt_valid;
endmodule
